// File: rtl/rst_pkg.sv
// rst_pkg -- shared types and helpers for the staged reset-release sequencer.
//
// Contents:
//   st_t      sequencer state encoding (HOLD, WAIT, DONE, FAULT)
//   stage_w   width of the stage index / seq_stage output for a given stage count
//   cnt_w     width of a down-counter that must hold values 0..max
//
// No configuration macros are used in this file.

package rst_pkg;

    typedef enum logic [1:0] {
        ST_HOLD  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DONE  = 2'd2,
        ST_FAULT = 2'd3
    } st_t;

    // A single stage still needs a one-bit index so the port never collapses to zero width.
    function automatic int stage_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // A counter whose maximum is 0 still gets one bit; it simply never leaves zero.
    function automatic int cnt_w(input int max);
        return (max > 0) ? $clog2(max + 1) : 1;
    endfunction

endpackage

// File: rtl/rst_seq_if.sv
// rst_seq_if -- bundle of the sequencer's control and status signals.
//
// Signals:
//   soft_rst   single-cycle request to re-run the whole release sequence
//   stage_rdy  per-stage ready, already synchronous to clk
//   stage_rst  per-stage active-high reset
//   seq_stage  index of the stage currently being processed
//   seq_done   all stages released and ready
//   seq_fault  sticky ready-timeout indication
//
// Modports:
//   master  the side that requests restarts and reports stage readiness
//   slave   the sequencer itself
//
// No configuration macros are used in this file.

interface rst_seq_if
    import rst_pkg::*;
#(
    parameter int NST = 4
);
    localparam int SW = stage_w(NST);

    logic           soft_rst;
    logic [NST-1:0] stage_rdy;
    logic [NST-1:0] stage_rst;
    logic [SW-1:0]  seq_stage;
    logic           seq_done;
    logic           seq_fault;

    modport master (
        output soft_rst,
        output stage_rdy,
        input  stage_rst,
        input  seq_stage,
        input  seq_done,
        input  seq_fault
    );

    modport slave (
        input  soft_rst,
        input  stage_rdy,
        output stage_rst,
        output seq_stage,
        output seq_done,
        output seq_fault
    );

endinterface

// File: rtl/rst_seq_cnt.sv
// rst_seq_cnt -- loadable saturating down-counter with a zero flag.
//
// Ports:
//   clk    clock
//   rst_n  synchronous active-low reset; reloads the counter with MAX
//   ld     reload with MAX (wins over en)
//   en     decrement by one; holds at zero instead of wrapping
//   zero   counter value is zero
//
// No configuration macros are used in this file.

module rst_seq_cnt
    import rst_pkg::*;
#(
    parameter int unsigned MAX = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ld,
    input  logic en,
    output logic zero
);

    localparam int W = cnt_w(int'(MAX));
    localparam logic [W-1:0] INIT = W'(MAX);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || ld) begin
            cnt <= INIT;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/rst_seq.sv
// rst_seq -- staged reset-release sequencer.
//
// Releases NST downstream reset domains one at a time in index order. Each
// stage waits DLY settle cycles, is released, and must then report ready
// before the next stage starts its settle delay. Any released stage dropping
// ready, or a soft_rst pulse, re-runs the whole sequence from stage 0.
//
// Ports:
//   clk    clock
//   rst_n  synchronous active-low reset
//   bus    rst_seq_if.slave: soft_rst, stage_rdy in; stage_rst, seq_stage,
//          seq_done, seq_fault out (all outputs registered)
//
// Parameters:
//   NST  number of sequenced stages (>= 1)
//   DLY  settle cycles before each stage release (>= 0)
//   TMO  ready-timeout cycles per stage (>= 1), only used with the macro
//
// Configuration macro:
//   RST_SEQ_TIMEOUT_EN  when defined, a stage that stays not-ready for TMO+1
//                       cycles after release sends the sequencer to FAULT;
//                       when undefined, WAIT is unbounded and seq_fault is 0.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_HOLD  | settle delay running for stage idx, stage idx still in reset
// ST_WAIT  | stage idx released, waiting for its stage_rdy
// ST_DONE  | every stage released and ready
// ST_FAULT | stage idx never became ready; all stages held in reset

module rst_seq
    import rst_pkg::*;
#(
    parameter int          NST = 4,
    parameter int unsigned DLY = 255,
    parameter int unsigned TMO = 65535
) (
    input  logic       clk,
    input  logic       rst_n,
    rst_seq_if.slave   bus
);

    localparam int IW = stage_w(NST);

    if (NST < 1) begin : g_bad_nst
        $error("rst_seq: NST must be at least 1");
    end
    if (TMO == 0) begin : g_bad_tmo
        $error("rst_seq: TMO must be at least 1");
    end

    st_t            state;
    logic [IW-1:0]  idx;
    logic [NST-1:0] stage_rst_q;
    logic           done_q;
    logic           fault_q;

    logic [NST-1:0] rel_mask;
    logic           rdy_cur;
    logic           last;
    logic           restart;
    logic           dly_zero;
    logic           dly_ld;
    logic           dly_en;

    assign rdy_cur = bus.stage_rdy[idx];
    assign last    = (idx == IW'(NST - 1));

    // Stages that must stay ready; the stage being waited on is deliberately
    // excluded, and nothing is watched while faulted.
    always_comb begin
        rel_mask = '0;
        case (state)
            ST_HOLD, ST_WAIT: begin
                for (int i = 0; i < NST; i++) begin
                    if (IW'(i) < idx) begin
                        rel_mask[i] = 1'b1;
                    end
                end
            end
            ST_DONE:  rel_mask = '1;
            default:  rel_mask = '0;
        endcase
    end

    assign restart = bus.soft_rst | (|(rel_mask & ~bus.stage_rdy));

    assign dly_ld = restart | ((state == ST_WAIT) & rdy_cur & ~last);
    assign dly_en = (state == ST_HOLD);

    rst_seq_cnt #(
        .MAX (DLY)
    ) u_dly_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .ld    (dly_ld),
        .en    (dly_en),
        .zero  (dly_zero)
    );

`ifdef RST_SEQ_TIMEOUT_EN
    logic tmo_zero;
    logic tmo_ld;
    logic tmo_en;

    // Loaded on the release edge so the count starts with the stage live.
    assign tmo_ld = (state == ST_HOLD) & dly_zero;
    assign tmo_en = (state == ST_WAIT) & ~rdy_cur;

    rst_seq_cnt #(
        .MAX (TMO)
    ) u_tmo_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .ld    (tmo_ld),
        .en    (tmo_en),
        .zero  (tmo_zero)
    );
`endif

    always_ff @(posedge clk) begin
        if (!rst_n || restart) begin
            state       <= ST_HOLD;
            idx         <= '0;
            stage_rst_q <= '1;
            done_q      <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            case (state)
                ST_HOLD: begin
                    if (dly_zero) begin
                        stage_rst_q[idx] <= 1'b0;
                        state            <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (rdy_cur) begin
                        if (last) begin
                            state  <= ST_DONE;
                            done_q <= 1'b1;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= ST_HOLD;
                        end
                    end
`ifdef RST_SEQ_TIMEOUT_EN
                    else if (tmo_zero) begin
                        state       <= ST_FAULT;
                        fault_q     <= 1'b1;
                        stage_rst_q <= '1;
                        done_q      <= 1'b0;
                    end
`endif
                end
                ST_DONE: begin
                end
                ST_FAULT: begin
                end
                default: begin
                    state <= ST_HOLD;
                end
            endcase
        end
    end

    assign bus.stage_rst = stage_rst_q;
    assign bus.seq_stage = idx;
    assign bus.seq_done  = done_q;
    assign bus.seq_fault = fault_q;

endmodule

// File: tb/tb_rst_seq.sv
// tb_rst_seq -- scoreboard bench for rst_seq.
//
// The reference model tracks the sequence in terms of elapsed cycles and a
// count of released stages; each driven cycle pushes the expected outputs for
// the following edge, and a monitor pops and compares after every edge.
// Honours RST_SEQ_TIMEOUT_EN when the bundle is built with it.

module tb_rst_seq;
    import rst_pkg::*;

    localparam int          NST = 3;
    localparam int unsigned DLY = 4;
    localparam int unsigned TMO = 10;
`ifdef RST_SEQ_TIMEOUT_EN
    localparam bit TMO_ON = 1'b1;
`else
    localparam bit TMO_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;

    rst_seq_if #(.NST(NST)) bus ();

    rst_seq #(
        .NST (NST),
        .DLY (DLY),
        .TMO (TMO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NST-1:0] rst;
        int             stage;
        bit             done;
        bit             fault;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference state: current stage, number of released stages, cycles spent
    // in the current hold/wait phase, and the two flags.
    int m_k, m_rel, m_t;
    bit m_done, m_fault;

    function automatic logic [NST-1:0] rst_pattern(input int rel);
        logic [NST-1:0] v;
        for (int i = 0; i < NST; i++) v[i] = (i >= rel);
        return v;
    endfunction

    function automatic void model_step(input bit rn, input bit sr, input logic [NST-1:0] rdy);
        bit   lost;
        exp_t e;
        lost = 1'b0;
        if (!m_fault) begin
            for (int i = 0; i < NST; i++) begin
                if ((m_done || i < m_k) && !rdy[i]) lost = 1'b1;
            end
        end
        if (!rn || sr || lost) begin
            m_k = 0; m_rel = 0; m_t = 0; m_done = 0; m_fault = 0;
        end else if (m_fault || m_done) begin
            // parked
        end else if (m_rel == m_k) begin
            if (m_t >= int'(DLY)) begin
                m_rel = m_k + 1;
                m_t   = 0;
            end else begin
                m_t++;
            end
        end else begin
            if (rdy[m_k]) begin
                if (m_k == NST - 1) begin
                    m_done = 1'b1;
                end else begin
                    m_k++;
                    m_t = 0;
                end
            end else if (TMO_ON && m_t >= int'(TMO)) begin
                m_fault = 1'b1;
                m_rel   = 0;
            end else begin
                m_t++;
            end
        end
        e.rst   = rst_pattern(m_rel);
        e.stage = m_k;
        e.done  = m_done;
        e.fault = m_fault;
        sb.push_back(e);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic drive(input bit rn, input bit sr, input logic [NST-1:0] rdy);
        @(negedge clk);
        rst_n         = rn;
        bus.soft_rst  = sr;
        bus.stage_rdy = rdy;
        model_step(rn, sr, rdy);
    endtask

    // Monitor: the DUT presents a fresh output set after every edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("stage_rst", 32'(bus.stage_rst), 32'(e.rst));
            chk("seq_stage", 32'(bus.seq_stage), 32'(e.stage));
            chk("seq_done",  32'(bus.seq_done),  32'(e.done));
            chk("seq_fault", 32'(bus.seq_fault), 32'(e.fault));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit found;
        bit mode;
        bit rn, sr;
        logic [NST-1:0] rdy;

        m_k = 0; m_rel = 0; m_t = 0; m_done = 0; m_fault = 0;
        rst_n         = 1'b0;
        bus.soft_rst  = 1'b0;
        bus.stage_rdy = '0;
        model_step(1'b0, 1'b0, '0);

        // Straight run with every stage ready.
        drive(1'b0, 1'b0, '0);
        repeat (30) drive(1'b1, 1'b0, '1);

        // One-cycle ready glitch on stage 0 while done.
        drive(1'b1, 1'b0, 3'b110);
        repeat (30) drive(1'b1, 1'b0, '1);

        // Stage 1 slow to come up (times out when the feature is built).
        repeat (25) drive(1'b1, 1'b0, 3'b101);
        drive(1'b1, 1'b1, '1);
        repeat (30) drive(1'b1, 1'b0, '1);

        // soft_rst on the very edge the last stage is first seen ready.
        found = 1'b0;
        for (int n = 0; n < 200 && !found; n++) begin
            if (m_k == NST - 1 && m_rel == NST && !m_done && !m_fault) begin
                drive(1'b1, 1'b1, '1);
                found = 1'b1;
            end else begin
                drive(1'b1, 1'b0, 3'b011);
            end
        end
        chk("reach_last_wait", 32'(found), 32'd1);
        repeat (30) drive(1'b1, 1'b0, '1);

        // rst_n pulled low in the middle of stage 2's settle delay.
        drive(1'b1, 1'b1, '1);
        found = 1'b0;
        for (int n = 0; n < 200 && !found; n++) begin
            if (m_k == 2 && m_rel == 2 && m_t == 1) begin
                drive(1'b0, 1'b0, '1);
                found = 1'b1;
            end else begin
                drive(1'b1, 1'b0, '1);
            end
        end
        chk("reach_mid_hold", 32'(found), 32'd1);
        repeat (30) drive(1'b1, 1'b0, '1);

        // Randomised traffic, alternating between mostly-ready and flaky stages.
        mode = 1'b0;
        for (int n = 0; n < 600; n++) begin
            if (n % 64 == 0) mode = 1'($urandom_range(0, 1));
            rn = ($urandom_range(0, 99) != 0);
            sr = ($urandom_range(0, 59) == 0);
            for (int i = 0; i < NST; i++) begin
                if (!mode)       rdy[i] = ($urandom_range(0, 31) != 0);
                else if (i == 0) rdy[i] = 1'b1;
                else             rdy[i] = ($urandom_range(0, 3) == 0);
            end
            drive(rn, sr, rdy);
        end

        repeat (3) @(posedge clk);
        #2;
        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rst_seq.md
Name: rst_seq

Overview:
Staged reset-release sequencer that sits directly downstream of the reset generator. Its synchronous reset input is driven from the generator's per-clock reset output, inverted to active-low. It releases NST downstream reset domains one at a time, in index order. Each stage is released only after a programmable settle delay and after the previous stage has reported ready. Used for ordered start-up: memory controller, then video/PLL users, then compute cores.

Parameters:
NST, 4, number of sequenced reset stages; min 1
DLY, 255, settle cycles counted before each stage release; min 0
TMO, 65535, ready-timeout cycles per stage; min 1; used only with RST_SEQ_TIMEOUT_EN

Ports:
clk  in  1  single clock
rst_n  in  1  synchronous active-low reset
soft_rst  in  1  single-cycle request to re-run the full sequence
stage_rdy  in  NST  per-stage ready; must be synchronous to clk (synchronizing is the caller's job)
stage_rst  out  NST  per-stage active-high reset, registered
seq_stage  out  max(1,$clog2(NST))  index of the stage currently being processed
seq_done  out  1  all stages released and ready, registered
seq_fault  out  1  ready timeout occurred, sticky, registered

Behaviour:
- Reset (rst_n=0 at a posedge):
  - state=HOLD, idx=0, dly_cnt=DLY.
  - stage_rst = all ones; seq_done=0; seq_fault=0; seq_stage=0.
- HOLD:
  - While dly_cnt!=0, decrement by one per cycle.
  - When dly_cnt==0: clear stage_rst[idx] on that edge and go to WAIT (tmo_cnt loaded with TMO).
  - stage_rst[0] therefore falls on the (DLY+1)th posedge with rst_n=1.
- WAIT, stage_rdy[idx]=1 sampled:
  - If idx==NST-1: go to DONE and set seq_done=1 on the same edge.
  - Otherwise: idx+1, dly_cnt=DLY, go to HOLD.
- DONE: hold all outputs; stay until a restart condition occurs.
- Released mask: stages below idx in HOLD/WAIT; all stages in DONE.
- Restart conditions: soft_rst=1, or any stage in the released mask sampled with stage_rdy=0 (rdy_lost).
- Restart action, on the next edge:
  - stage_rst = all ones; seq_done=0; seq_fault=0.
  - idx=0, dly_cnt=DLY, state=HOLD.
- Priority: rst_n low > restart > normal transition. A restart coinciding with a final ack means seq_done stays 0.
- The stage being waited on is not in the released mask; its rdy=0 in WAIT is the normal wait condition.
- seq_stage always equals idx.
- Counter widths:
  - dly_cnt: $clog2(DLY+1).
  - tmo_cnt: $clog2(TMO+1).
  - No wrap; both counters saturate at 0.
- Stages above idx are never released out of order.

Optional Feature:
Macro RST_SEQ_TIMEOUT_EN.
- Defined:
  - In WAIT, tmo_cnt decrements each cycle stage_rdy[idx]=0.
  - If tmo_cnt==0 and rdy is still 0 → go to FAULT: seq_fault=1, stage_rst all ones, seq_done=0.
  - Fault is raised TMO+1 cycles after the stage release.
  - FAULT is left only by rst_n or soft_rst (a normal restart).
- Undefined:
  - WAIT waits indefinitely; no timeout counter logic is built.
  - seq_fault is tied 0; FAULT state is unreachable; TMO is ignored.

Decomposition:
- Shared package rst_pkg holds:
  - a 2-bit state typedef: ST_HOLD=0, ST_WAIT=1, ST_DONE=2, ST_FAULT=3;
  - a helper function for the seq_stage width.
- One sub-module, rst_seq_cnt: a loadable saturating down-counter with a zero flag.
  - Parameter: MAX.
  - Ports: clk, rst_n, ld, en, zero.
  - Instantiated for dly_cnt, and for tmo_cnt under the macro.

Test Plan:
1. NST=2, DLY=4, stage_rdy tied 11, rst_n released at edge 0 → stage_rst[0] falls at edge 5; stage_rst[1] falls 6 edges later; seq_done=1 on the edge after stage_rdy[1] is sampled.
2. NST=3, DLY=2, stage_rdy[1] held 0 for 20 cycles → seq_stage=1, stage_rst=100 throughout; releasing rdy[1] advances to stage 2.
3. In DONE, pulse stage_rdy[0]=0 for 1 cycle → next edge stage_rst=all ones, seq_done=0, seq_stage=0; the sequence re-runs with identical timing to case 1.
4. soft_rst pulse on the same edge that stage_rdy[NST-1] is first sampled high → seq_done stays 0 and the sequence restarts from stage 0.
5. RST_SEQ_TIMEOUT_EN defined, TMO=10, stage_rdy[1] never asserted → seq_fault=1 exactly 11 edges after stage_rst[1] falls, with stage_rst all ones. A later soft_rst clears the fault and restarts.
6. rst_n pulled low mid-HOLD for stage 2 → next edge all outputs at reset values; DLY=0 variant releases stage 0 on the first edge after rst_n=1.
